alu_mc: RTL and testbench

//  Multi-cycle, parametrised EX-stage ALU for the npc core. Accepts one op per valid/ready

---
 rtl/alu_mc_if.sv | 29 ++
 rtl/alu_mc.sv | 178 +++++++++++++++++
 tb/tb_alu_mc.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for the alu_mc multi-cycle EX-stage ALU.
// master = issuing pipeline stage, slave = the ALU.
interface alu_mc_if #(
    parameter int XLEN = 64,
    parameter int OP_W = 4
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] alu_op;
    logic            word;
    logic [XLEN-1:0] alu_src1;
    logic [XLEN-1:0] alu_src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_res;
    logic            zero;
    logic            illegal;

    modport master (
        output flush, in_valid, alu_op, word, alu_src1, alu_src2, out_ready,
        input  in_ready, out_valid, alu_res, zero, illegal
    );

    modport slave (
        input  flush, in_valid, alu_op, word, alu_src1, alu_src2, out_ready,
        output in_ready, out_valid, alu_res, zero, illegal
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: one-cycle logic/arith ops, shift-add MUL, restoring DIVU/REMU.
// Define ALU_MC_DIV_EN to build the divider; otherwise DIVU/REMU report illegal.
module alu_mc #(
    parameter int XLEN = 64,
    parameter int OP_W = 4
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = SH_W + 1;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_DIVU = OP_W'(11);
    localparam logic [OP_W-1:0] OP_REMU = OP_W'(12);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last_cnt;
    logic [OP_W-1:0] op_q;
    logic            word_q;
    logic [XLEN-1:0] opa, opb, acc;
    logic [XLEN-1:0] res_q;
    logic            in_ready_q, out_valid_q, illegal_q;

    logic [XLEN-1:0] a_u, a_s, b_u, b_s;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] r1;
    logic            iter, ill1;
    logic [XLEN-1:0] mul_nxt, it_res;
`ifdef ALU_MC_DIV_EN
    logic [XLEN:0]   div_sh, div_diff;
    logic [XLEN-1:0] quo_nxt, rem_nxt;
`endif

    // Word-mode results are the low 32 bits sign-extended to XLEN.
    function automatic logic [XLEN-1:0] fit(input logic w, input logic [XLEN-1:0] v);
        return w ? XLEN'($signed(v[31:0])) : v;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        a_u   = bus.word ? XLEN'(bus.alu_src1[31:0]) : bus.alu_src1;
        a_s   = bus.word ? XLEN'($signed(bus.alu_src1[31:0])) : bus.alu_src1;
        b_u   = bus.word ? XLEN'(bus.alu_src2[31:0]) : bus.alu_src2;
        b_s   = bus.word ? XLEN'($signed(bus.alu_src2[31:0])) : bus.alu_src2;
        shamt = bus.word ? SH_W'(bus.alu_src2[4:0]) : bus.alu_src2[SH_W-1:0];
        r1    = '0;
        iter  = 1'b0;
        ill1  = 1'b0;
        case (bus.alu_op)
            OP_ADD:  r1 = a_u + b_u;
            OP_SUB:  r1 = a_u - b_u;
            OP_SLL:  r1 = a_u << shamt;
            OP_SLT:  r1 = XLEN'($signed(a_s) < $signed(b_s));
            OP_SLTU: r1 = XLEN'(a_u < b_u);
            OP_XOR:  r1 = a_u ^ b_u;
            OP_SRL:  r1 = a_u >> shamt;
            OP_SRA:  r1 = $signed(a_s) >>> shamt;
            OP_OR:   r1 = a_u | b_u;
            OP_AND:  r1 = a_u & b_u;
            OP_MUL:  iter = 1'b1;
`ifdef ALU_MC_DIV_EN
            OP_DIVU, OP_REMU: begin
                if (b_u == '0) r1 = (bus.alu_op == OP_DIVU) ? '1 : a_u;
                else           iter = 1'b1;
            end
`endif
            default: ill1 = 1'b1;
        endcase
    end

    always_comb begin
        mul_nxt = acc + (opb[0] ? opa : '0);
        it_res  = (op_q == OP_MUL) ? mul_nxt : '0;
`ifdef ALU_MC_DIV_EN
        // Restoring step: shift the next dividend bit into the partial remainder, trial-subtract.
        div_sh   = {acc, opa[XLEN-1]};
        div_diff = div_sh - {1'b0, opb};
        quo_nxt  = {opa[XLEN-2:0], ~div_diff[XLEN]};
        rem_nxt  = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
        if (op_q == OP_DIVU)      it_res = quo_nxt;
        else if (op_q == OP_REMU) it_res = rem_nxt;
`endif
    end

    assign last_cnt = word_q ? CNT_W'(31) : CNT_W'(XLEN - 1);

    // NOTE: state is updated with non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            illegal_q   <= 1'b0;
            count       <= '0;
            op_q        <= '0;
            word_q      <= 1'b0;
            opa         <= '0;
            opb         <= '0;
            acc         <= '0;
        end else if (bus.flush) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_q       <= bus.alu_op;
                    word_q     <= bus.word;
                    count      <= '0;
                    acc        <= '0;
                    opa        <= a_u;
                    opb        <= b_u;
                    in_ready_q <= 1'b0;
                    if (iter) begin
                        state <= BUSY;
`ifdef ALU_MC_DIV_EN
                        // Word divide: park the 32-bit dividend at the top so 32 steps consume it.
                        if (bus.alu_op != OP_MUL && bus.word) opa <= a_u << (XLEN - 32);
`endif
                    end else begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        res_q       <= fit(bus.word, r1);
                        illegal_q   <= ill1;
                    end
                end
                BUSY: begin
                    count <= count + 1'b1;
                    if (op_q == OP_MUL) begin
                        acc <= mul_nxt;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end
`ifdef ALU_MC_DIV_EN
                    else begin
                        acc <= rem_nxt;
                        opa <= quo_nxt;
                    end
`endif
                    if (count == last_cnt) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        res_q       <= fit(word_q, it_res);
                        illegal_q   <= 1'b0;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_res   = res_q;
    assign bus.illegal   = illegal_q;
    assign bus.zero      = (res_q == '0);
endmodule

// File: tb/tb_alu_mc.sv
// Directed scoreboard bench for alu_mc (XLEN=64); expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;
    localparam int XLEN = 64;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                           OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_OR = 4'd8, OP_AND = 4'd9, OP_MUL = 4'd10, OP_DIVU = 4'd11,
                           OP_REMU = 4'd12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_mc_if #(.XLEN(XLEN), .OP_W(4)) bus ();
    alu_mc #(.XLEN(XLEN), .OP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [63:0] res;
        logic        ill;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] res, input logic ill, input int lat, input string tag);
        exp_t e;
        e.res = res; e.ill = ill; e.lat = lat; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        check({tag, " accept_ready"}, 64'(bus.in_ready), 64'd1);
        bus.alu_op   = op;
        bus.word     = w;
        bus.alu_src1 = a;
        bus.alu_src2 = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   n;
        logic ready_seen;
        e = sb.pop_front();
        n = 0;
        ready_seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (bus.in_ready) ready_seen = 1'b1;
        end while (!bus.out_valid && n < 200);
        check({e.tag, " latency"}, 64'(n), 64'(e.lat));
        check({e.tag, " in_ready_low"}, 64'(ready_seen), 64'd0);
        check({e.tag, " res"}, bus.alu_res, e.res);
        check({e.tag, " zero"}, 64'(bus.zero), 64'(e.res == 64'd0));
        check({e.tag, " illegal"}, 64'(bus.illegal), 64'(e.ill));
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            check({e.tag, " hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({e.tag, " hold_ready"}, 64'(bus.in_ready), 64'd0);
            check({e.tag, " hold_res"}, bus.alu_res, e.res);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check({e.tag, " post_ready"}, 64'(bus.in_ready), 64'd1);
        check({e.tag, " post_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic one(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input logic ill, input int lat, input string tag);
        send(op, w, a, b, res, ill, lat, tag);
        collect(0);
    endtask

    initial begin
        logic seen;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.alu_op = '0; bus.word = 1'b0; bus.alu_src1 = '0; bus.alu_src2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset alu_res", bus.alu_res, 64'd0);
        check("reset zero", 64'(bus.zero), 64'd1);
        check("reset illegal", 64'(bus.illegal), 64'd0);

        one(OP_ADD, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1, "add_w");
        one(OP_ADD, 1'b0, '1, 64'd1, 64'd0, 1'b0, 1, "add_wrap");
        one(OP_SUB, 1'b0, 64'd0, 64'd1, '1, 1'b0, 1, "sub_wrap");
        one(OP_SLT, 1'b0, '1, 64'd1, 64'd1, 1'b0, 1, "slt");
        one(OP_SLTU, 1'b0, '1, 64'd1, 64'd0, 1'b0, 1, "sltu");
        one(OP_SLT, 1'b1, 64'h8000_0000, 64'd1, 64'd1, 1'b0, 1, "slt_w");
        one(OP_SLTU, 1'b1, 64'hFFFF_FFFF_0000_0001, 64'd2, 64'd1, 1'b0, 1, "sltu_w");
        one(OP_SLL, 1'b0, 64'd1, 64'h7F, 64'h8000_0000_0000_0000, 1'b0, 1, "sll");
        one(OP_SLL, 1'b1, 64'd1, 64'h3F, 64'hFFFF_FFFF_8000_0000, 1'b0, 1, "sll_w");
        one(OP_SRL, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 1, "srl");
        one(OP_SRL, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'd1, 1'b0, 1, "srl_w");
        one(OP_SRA, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 1, "sra");
        one(OP_XOR, 1'b0, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, 1, "xor");
        one(OP_OR, 1'b0, 64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0, 1, "or");
        one(OP_AND, 1'b0, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1, "and");
        one(4'd15, 1'b0, 64'd3, 64'd4, 64'd0, 1'b1, 1, "illegal_op");

`ifdef ALU_MC_DIV_EN
        one(OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0, 65, "divu");
        one(OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0, 65, "remu");
        one(OP_DIVU, 1'b1, 64'hABCD_0000_0000_0064, 64'hFFFF_0000_0000_0007, 64'd14, 1'b0, 33, "divu_w");
        one(OP_DIVU, 1'b0, 64'h1234, 64'd0, '1, 1'b0, 1, "divu_by0");
        one(OP_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1'b0, 1, "remu_by0");
        one(OP_REMU, 1'b1, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1, "remu_w_by0");
`else
        one(OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd0, 1'b1, 1, "divu_nodiv");
        one(OP_REMU, 1'b0, 64'd100, 64'd7, 64'd0, 1'b1, 1, "remu_nodiv");
        one(OP_DIVU, 1'b0, 64'h1234, 64'd0, 64'd0, 1'b1, 1, "divu_by0_nodiv");
`endif

        send(OP_SUB, 1'b0, 64'd5, 64'd5, 64'd0, 1'b0, 1, "sub_hold");
        collect(2);

        one(OP_MUL, 1'b1, 64'h0800_0000, 64'h10, 64'hFFFF_FFFF_8000_0000, 1'b0, 33, "mul_w");

        // Reset in the middle of an iterative multiply.
        send(OP_MUL, 1'b0, '1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65, "mul_rst");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("mid_rst out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst alu_res", bus.alu_res, 64'd0);
        check("mid_rst zero", 64'(bus.zero), 64'd1);
        one(OP_MUL, 1'b0, '1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65, "mul");

        one(OP_SRA, 1'b1, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 1'b0, 1, "sra_w");

        // Flush while BUSY, with a competing in_valid in the same cycle.
        send(OP_MUL, 1'b0, 64'd7, 64'd9, 64'd63, 1'b0, 65, "mul_flush");
        void'(sb.pop_back());
        repeat (5) @(negedge clk);
        bus.flush = 1'b1; bus.in_valid = 1'b1;
        bus.alu_op = OP_ADD; bus.word = 1'b0; bus.alu_src1 = 64'd1; bus.alu_src2 = 64'd1;
        @(posedge clk);
        #1 bus.flush = 1'b0; bus.in_valid = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_busy out_valid_seen", 64'(seen), 64'd0);
        check("flush_busy in_ready", 64'(bus.in_ready), 64'd1);

        // Flush in IDLE: the concurrent in_valid must not be taken.
        bus.flush = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0; bus.in_valid = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_idle out_valid_seen", 64'(seen), 64'd0);

        one(OP_ADD, 1'b0, 64'd2, 64'd3, 64'd5, 1'b0, 1, "add_after_flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
